multisim_stream_fifo: RTL and testbench

Synchronous first-word-fall-through FIFO that decouples a multisim stream producer from its consumer. It sits directly downstream of `multisim_client_pull`, consuming that block's `data_vld`/`data` stream and driving its `data_rdy`. The FIFO absorbs DPI fetch stalls and consumer back-pressure so neither side sees the other's combinational ready path.

---
 rtl/multisim_stream_fifo_chk.sv | 26 ++
 rtl/multisim_stream_fifo_mem.sv | 32 +++
 rtl/multisim_stream_fifo.sv | 97 +++++++++
 tb/tb_multisim_stream_fifo.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/multisim_stream_fifo_chk.sv
// Simulation-only protocol checks for multisim_stream_fifo.
module multisim_stream_fifo_chk #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  push,
    input logic                  pop,
    input logic [CNT_W-1:0]      count,
    input logic                  out_vld,
    input logic                  out_rdy,
    input logic [DATA_WIDTH-1:0] out_data
);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == CNT_W'(DEPTH))));

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(pop && (count == {CNT_W{1'b0}})));

    a_head_stable: assert property (@(posedge clk) disable iff (rst)
        (out_vld && !out_rdy) |=> $stable(out_data));

endmodule

// File: rtl/multisim_stream_fifo_mem.sv
// Register array for multisim_stream_fifo: one synchronous write port,
// one asynchronous read port, all entries cleared by reset.
module multisim_stream_fifo_mem #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Storage: clear every entry on reset, otherwise write the addressed entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/multisim_stream_fifo.sv
// First-word-fall-through FIFO between multisim_client_pull and its consumer.
// Ready toward the producer depends only on registered occupancy, so no
// combinational path exists from out_rdy to in_rdy or from in_* to out_*.
module multisim_stream_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_vld,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         in_rdy,
    output logic                         out_vld,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_rdy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $fatal(1, "multisim_stream_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    assign in_rdy  = !rst && (count_r != CNT_W'(DEPTH));
    assign out_vld = (count_r != {CNT_W{1'b0}});
    assign push_s  = in_vld && in_rdy;
    assign pop_s   = out_vld && out_rdy;
    assign count   = count_r;

    // Pointers advance on their own handshake and wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Occupancy: +1 on push only, -1 on pop only, unchanged otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    multisim_stream_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (in_data),
        .raddr (rd_ptr_r),
        .rdata (out_data)
    );

    multisim_stream_fifo_chk #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .pop      (pop_s),
        .count    (count_r),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data)
    );

endmodule

// File: tb/tb_multisim_stream_fifo.sv
// Self-checking bench for multisim_stream_fifo against a queue reference model.
module tb_multisim_stream_fifo;

    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_vld;
    logic [DW-1:0] in_data;
    logic          in_rdy;
    logic          out_vld;
    logic [DW-1:0] out_data;
    logic          out_rdy;
    logic [2:0]    count;

    int            total = 0;
    int            bad   = 0;
    int            delivered = 0;
    logic [63:0]   q[$];

    multisim_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_rdy  (out_rdy),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, "_cnt"}, 64'(count), 64'(q.size()));
        check_val({tag, "_vld"}, 64'(out_vld), 64'(q.size() != 0));
        if (q.size() != 0) check_val({tag, "_data"}, out_data, q[0]);
    endtask

    // One clock cycle: drive at negedge, update model at posedge, check at next negedge.
    task automatic cycle(input string tag, input logic r, input logic iv,
                         input logic [63:0] d, input logic ordy, output logic pushed);
        logic do_push;
        logic do_pop;
        rst     = r;
        in_vld  = iv;
        in_data = d;
        out_rdy = ordy;
        do_push = !r && iv && (q.size() < DEPTH);
        do_pop  = !r && ordy && (q.size() != 0);
        #1;
        check_val({tag, "_rdy"}, 64'(in_rdy), 64'(!r && (q.size() < DEPTH)));
        @(posedge clk);
        if (r) begin
            q.delete();
        end else begin
            if (do_pop) begin
                void'(q.pop_front());
                delivered++;
            end
            if (do_push) q.push_back(d);
        end
        @(negedge clk);
        check_outputs(tag);
        pushed = do_push;
    endtask

    initial begin
        logic        p;
        logic [63:0] fill_vals[5];
        logic [63:0] pend;
        logic        hold;
        int          sent;
        int          start_del;
        int          cyc;

        rst = 1'b1; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
        @(negedge clk);

        // Reset held three cycles with in_vld asserted.
        for (int i = 0; i < 3; i++) cycle("rst", 1'b1, 1'b1, 64'hdead, 1'b0, p);
        check_val("rst_data", out_data, 64'h0);

        // Fill to full with out_rdy low, fifth beat held off.
        fill_vals[0] = 64'h11; fill_vals[1] = 64'h22; fill_vals[2] = 64'h33;
        fill_vals[3] = 64'h44; fill_vals[4] = 64'h55;
        for (int i = 0; i < 4; i++) cycle("fill", 1'b0, 1'b1, fill_vals[i], 1'b0, p);
        check_val("full_cnt", 64'(count), 64'd4);
        cycle("hold", 1'b0, 1'b1, fill_vals[4], 1'b0, p);
        check_val("hold_refused", 64'(p), 64'd0);

        // Full with simultaneous pop: pop only, then the held push proceeds.
        cycle("fullpop", 1'b0, 1'b1, fill_vals[4], 1'b1, p);
        check_val("fullpop_cnt", 64'(count), 64'd3);
        check_val("fullpop_head", out_data, 64'h22);
        cycle("push55", 1'b0, 1'b1, fill_vals[4], 1'b1, p);
        check_val("push55_acc", 64'(p), 64'd1);
        for (int i = 0; i < 10 && q.size() != 0; i++) cycle("drain", 1'b0, 1'b0, 64'h0, 1'b1, p);
        check_val("drain_cnt", 64'(count), 64'd0);

        // Streaming with in_vld = out_rdy = 1: occupancy sits at one.
        for (int i = 0; i < 20; i++) begin
            cycle("stream", 1'b0, 1'b1, 64'(256 + i), 1'b1, p);
            check_val("stream_cnt", 64'(count), 64'd1);
        end
        for (int i = 0; i < 10 && q.size() != 0; i++) cycle("drain2", 1'b0, 1'b0, 64'h0, 1'b1, p);

        // Wrap-around: 3*DEPTH+1 random beats, producer holds refused beats.
        sent = 0; start_del = delivered; hold = 1'b0; cyc = 0;
        pend = {$urandom, $urandom};
        while ((delivered - start_del) < 3 * DEPTH + 1 && cyc < 500) begin
            logic iv;
            iv = hold || ((sent < 3 * DEPTH + 1) && ($urandom_range(0, 1) == 1));
            cycle("wrap", 1'b0, iv, pend, ($urandom_range(0, 2) != 0), p);
            if (p) begin
                sent++;
                pend = {$urandom, $urandom};
                hold = 1'b0;
            end else begin
                hold = iv;
            end
            cyc++;
        end
        check_val("wrap_done", 64'(delivered - start_del), 64'(3 * DEPTH + 1));

        // Reset mid-stream at count 2 discards buffered beats.
        cycle("pre_a", 1'b0, 1'b1, 64'haaaa, 1'b0, p);
        cycle("pre_b", 1'b0, 1'b1, 64'hbbbb, 1'b0, p);
        check_val("pre_cnt", 64'(count), 64'd2);
        cycle("midrst", 1'b1, 1'b0, 64'h0, 1'b0, p);
        check_val("midrst_vld", 64'(out_vld), 64'd0);
        cycle("post", 1'b0, 1'b1, 64'hcccc, 1'b0, p);
        check_val("post_head", out_data, 64'hcccc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
